// File: rtl/pipe_skid_stage_pkg.sv
// rtl/pipe_skid_stage_pkg.sv - shared pipeline types and constants for the skid stage
package pipe_skid_stage_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_e;

  localparam int unsigned BUBBLE_W = 16;

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [BUBBLE_W-1:0] sat_inc(input logic [BUBBLE_W-1:0] v);
    return (&v) ? v : v + {{(BUBBLE_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/pipe_skid_stage_entry_reg.sv
// rtl/pipe_skid_stage_entry_reg.sv - one {pc, data} holding register with load and payload clear
module pipe_entry_reg
  import pipe_skid_stage_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clr_payload_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [DATA_W-1:0] data_o
);

  logic [PC_W-1:0]   pc_q;
  logic [DATA_W-1:0] data_q;

  // Clearing touches only the payload; the PC is kept for debug visibility.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= '0;
      data_q <= '0;
    end else if (clr_payload_i) begin
      data_q <= '0;
    end else if (load_i) begin
      pc_q   <= pc_i;
      data_q <= data_i;
    end
  end

  assign pc_o   = pc_q;
  assign data_o = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - two-entry skid pipeline stage with freeze, flush and bubble counter
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int PC_W       = 32,
  parameter int N_FRZ      = 2,
  parameter int FLUSH_ZERO = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FRZ-1:0]    freeze,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PC_W-1:0]     in_pc,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_W-1:0]     out_pc,
  output logic [DATA_W-1:0]   out_data,
  output logic [BUBBLE_W-1:0] bubble_cnt
);

  occ_state_e state_q, state_d;

  logic frz, in_fire, out_fire;
  logic main_load, skid_load, main_from_skid, clr_payload;

  logic [PC_W-1:0]     main_pc, skid_pc, main_pc_in;
  logic [DATA_W-1:0]   main_data, skid_data, main_data_in;
  logic [BUBBLE_W-1:0] bubble_q;

  assign frz         = |freeze;
  assign in_ready    = (state_q != OCC_TWO) & ~frz & ~flush;
  assign out_valid   = (state_q != OCC_EMPTY);
  assign in_fire     = in_valid & in_ready;
  assign out_fire    = out_valid & out_ready & ~frz;
  assign clr_payload = flush & (FLUSH_ZERO != 0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OCC_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else if (!frz) begin
      case (state_q)
        OCC_EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_d   = OCC_TWO;
          end else if (out_fire) begin
            state_d = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          // Upstream is blocked here, so only a drain can happen.
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            state_d        = OCC_ONE;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  assign main_pc_in   = main_from_skid ? skid_pc : in_pc;
  assign main_data_in = main_from_skid ? skid_data : in_data;

  pipe_entry_reg #(.PC_W(PC_W), .DATA_W(DATA_W)) u_main (
    .clk           (clk),
    .rst           (rst),
    .load_i        (main_load),
    .clr_payload_i (clr_payload),
    .pc_i          (main_pc_in),
    .data_i        (main_data_in),
    .pc_o          (main_pc),
    .data_o        (main_data)
  );

  pipe_entry_reg #(.PC_W(PC_W), .DATA_W(DATA_W)) u_skid (
    .clk           (clk),
    .rst           (rst),
    .load_i        (skid_load),
    .clr_payload_i (clr_payload),
    .pc_i          (in_pc),
    .data_i        (in_data),
    .pc_o          (skid_pc),
    .data_o        (skid_data)
  );

  // Counts empty cycles even while frozen or flushing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_q <= '0;
    end else if (!out_valid) begin
      bubble_q <= sat_inc(bubble_q);
    end
  end

  assign out_pc     = main_pc;
  assign out_data   = main_data;
  assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - directed self-checking bench for pipe_skid_stage
module tb_pipe_skid_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  freeze;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_data;
  logic [15:0] bubble_cnt;

  int errors = 0;
  int checks = 0;

  pipe_skid_stage #(.DATA_W(32), .PC_W(32), .N_FRZ(2), .FLUSH_ZERO(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .freeze     (freeze),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_data   (out_data),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; freeze = 2'b00; flush = 1'b0; in_valid = 1'b0;
    in_pc = '0; in_data = '0; out_ready = 1'b0;
    #2;
    chk("reset_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_pc", out_pc, 32'd0);
    chk("reset_data", out_data, 32'd0);
    chk("reset_bubble", {16'b0, bubble_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("bubble_first", {16'b0, bubble_cnt}, 32'd1);

    // pass-through and full-throughput stream
    in_valid = 1'b1; in_pc = 32'h100; in_data = 32'hE3A01005; out_ready = 1'b1;
    #1 chk("pt_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    chk("pt_valid", {31'b0, out_valid}, 32'd1);
    chk("pt_pc", out_pc, 32'h100);
    chk("pt_data", out_data, 32'hE3A01005);
    for (int i = 1; i <= 4; i++) begin
      in_pc = 32'h100 + 32'(4 * i); in_data = 32'(i * 32'h11);
      #1 chk("stream_ready", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      chk("stream_pc", out_pc, 32'h100 + 32'(4 * i));
      chk("stream_data", out_data, 32'(i * 32'h11));
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_drained", {31'b0, out_valid}, 32'd0);
    chk("bubble_after_stream", {16'b0, bubble_cnt}, 32'd2);

    // backpressure: two accepts, third refused, order preserved
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h10; in_data = 32'hA;
    #1 chk("bp_ready_a", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    chk("bp_data_a", out_data, 32'hA);
    in_pc = 32'h14; in_data = 32'hB;
    #1 chk("bp_ready_b", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    chk("bp_hold_a", out_data, 32'hA);
    in_pc = 32'h18; in_data = 32'hC;
    #1 chk("bp_ready_c", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    chk("bp_still_a", out_data, 32'hA);
    out_ready = 1'b1;
    #1 chk("bp_release_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    chk("bp_data_b", out_data, 32'hB);
    chk("bp_pc_b", out_pc, 32'h14);
    @(negedge clk);
    chk("bp_data_c", out_data, 32'hC);
    chk("bp_pc_c", out_pc, 32'h18);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_empty", {31'b0, out_valid}, 32'd0);
    chk("bubble_after_bp", {16'b0, bubble_cnt}, 32'd3);

    // freeze in ONE
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h200; in_data = 32'h55AA;
    @(negedge clk);
    out_ready = 1'b1; freeze = 2'b10; in_pc = 32'h204; in_data = 32'h66BB;
    #1 chk("frz_in_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("frz_valid", {31'b0, out_valid}, 32'd1);
      chk("frz_pc", out_pc, 32'h200);
      chk("frz_data", out_data, 32'h55AA);
    end
    freeze = 2'b00;
    @(negedge clk);
    chk("frz_resume_data", out_data, 32'h66BB);
    chk("frz_resume_pc", out_pc, 32'h204);
    in_valid = 1'b0;
    @(negedge clk);
    chk("frz_empty", {31'b0, out_valid}, 32'd0);
    chk("bubble_after_frz", {16'b0, bubble_cnt}, 32'd4);

    // flush from TWO with freeze and in_valid asserted
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h400; in_data = 32'h1111;
    @(negedge clk);
    in_pc = 32'h404; in_data = 32'h2222;
    @(negedge clk);
    flush = 1'b1; freeze = 2'b01; in_pc = 32'h408; in_data = 32'h3333;
    #1 chk("fl_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    chk("fl_valid", {31'b0, out_valid}, 32'd0);
    chk("fl_data_zero", out_data, 32'd0);
    chk("fl_pc_kept", out_pc, 32'h400);
    flush = 1'b0; freeze = 2'b00; in_valid = 1'b0;
    @(negedge clk);
    chk("fl_discarded", {31'b0, out_valid}, 32'd0);
    chk("bubble_after_flush", {16'b0, bubble_cnt}, 32'd6);

    // async reset while in TWO
    in_valid = 1'b1; in_pc = 32'h500; in_data = 32'hDEAD;
    @(negedge clk);
    in_pc = 32'h504; in_data = 32'hBEEF;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_ready", {31'b0, in_ready}, 32'd0);
    chk("pre_rst_bubble", {16'b0, bubble_cnt}, 32'd7);
    rst = 1'b1;
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_bubble", {16'b0, bubble_cnt}, 32'd0);
    rst = 1'b0;

    // bubble counter saturation
    repeat (65534) @(negedge clk);
    chk("sat_fffe", {16'b0, bubble_cnt}, 32'hFFFE);
    @(negedge clk);
    chk("sat_ffff", {16'b0, bubble_cnt}, 32'hFFFF);
    repeat (4465) @(negedge clk);
    chk("sat_hold", {16'b0, bubble_cnt}, 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter DATA_W, 32, payload (instruction) width in bits.
REQ-002 SHALL have parameter PC_W, 32, program-counter width in bits.
REQ-003 SHALL have parameter N_FRZ, 2, number of independent freeze sources (e.g. hazard, cache).
REQ-004 SHALL have parameter FLUSH_ZERO, 1, when 1 flush zeroes stored payloads; when 0 payloads are retained.
REQ-005 SHALL have port clk  input  1  clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port freeze  input  N_FRZ  per-source stall; any bit set freezes the stage.
REQ-008 SHALL have port flush  input  1  discard all held entries.
REQ-009 SHALL have ports in_valid input 1, in_ready output 1, in_pc input PC_W, in_data input DATA_W  upstream handshake and payload.
REQ-010 SHALL have ports out_valid output 1, out_ready input 1, out_pc output PC_W, out_data output DATA_W  downstream handshake and payload.
REQ-011 SHALL have port bubble_cnt  output  16  saturating count of cycles with out_valid=0 since reset.

Function
REQ-012 SHALL define frz = OR-reduce(freeze); in_fire = in_valid & in_ready; out_fire = out_valid & out_ready & ~frz.
REQ-013 SHALL hold two entries (main, skid) with occupancy state EMPTY, ONE, TWO; data leaves in arrival order.
REQ-014 SHALL drive in_ready = (state != TWO) & ~frz & ~flush.
REQ-015 SHALL drive out_valid = (state != EMPTY); out_pc/out_data from main entry, registered, no combinational path from in_* to out_*.
REQ-016 SHALL transition: EMPTY+in_fire -> ONE; ONE+in_fire+~out_fire -> TWO; ONE+out_fire+~in_fire -> EMPTY; TWO+out_fire -> ONE (skid moves to main); simultaneous in/out in ONE stays ONE with new main.
REQ-017 SHALL give latency of exactly one cycle from in_fire in EMPTY to out_valid=1.
REQ-018 SHALL, when frz=1 and flush=0, change no state, entry or counter value except bubble_cnt.
REQ-019 SHALL, on flush=1, go to EMPTY next edge regardless of frz, out_ready or in_valid; the same-cycle input is discarded.
REQ-020 SHALL, on flush, zero main and skid payloads if FLUSH_ZERO=1; PC fields SHALL retain their previous values.
REQ-021 SHALL hold out_pc/out_data stable while out_valid=1 and out_fire=0.
REQ-022 SHALL increment bubble_cnt each edge where out_valid=0, saturating at 16'hFFFF with no wrap.

Reset
REQ-023 SHALL, on rst=1, asynchronously force state EMPTY, all PC and payload registers to 0, bubble_cnt to 0.
REQ-024 SHALL give rst priority over flush, freeze and handshakes, including mid-transfer; entries in flight are lost.

Structure
REQ-025 SHALL place the occupancy state enum (EMPTY, ONE, TWO) and the bubble-counter width constant in the shared pipeline package.
REQ-026 SHALL implement one sub-module, pipe_entry_reg, storing one {pc, data} entry with load, clear-payload and async-reset controls; instantiated twice.

Verification
REQ-027 Reset: rst pulse mid-operation with state TWO -> out_valid=0, out_pc=0, out_data=0, bubble_cnt=0 immediately, before next clk edge.
REQ-028 Pass-through: in_valid=1, in_pc=0x100, in_data=0xE3A01005, out_ready=1 -> out_valid=1, out_pc=0x100 next cycle; back-to-back stream keeps full throughput.
REQ-029 Backpressure: out_ready=0 while feeding 0xA, 0xB, 0xC -> in_ready drops after two accepts, 0xC not accepted; releasing out_ready delivers 0xA, 0xB, then 0xC, in order.
REQ-030 Freeze: freeze=2'b10 for 3 cycles in state ONE with out_ready=1 -> no out_fire, outputs unchanged, in_ready=0; resumes cleanly after release.
REQ-031 Flush: state TWO, flush=1 with freeze=2'b01 and in_valid=1 -> next cycle EMPTY, out_data=0 (FLUSH_ZERO=1), out_pc retained, input discarded.
REQ-032 Counter: hold EMPTY for 70000 cycles -> bubble_cnt saturates at 0xFFFF and stays.
